// File: rtl/histogram_engine_if.sv
// ---------------------------------------------------------------------------
// histogram_engine_if
// Word-oriented JTAG master bus shared by the histogram engine and the
// JTAG-to-Avalon bridge.
//   m_addr      : word address            (master -> slave)
//   m_read      : 1-cycle read strobe     (master -> slave)
//   m_write     : 1-cycle write strobe    (master -> slave)
//   m_writedata : write data              (master -> slave)
//   s_readdata  : read data, held         (slave -> master)
//   s_readvalid : read data qualifier     (slave -> master)
// ---------------------------------------------------------------------------
interface histogram_engine_if;
   logic [31:0] m_addr;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [31:0] s_readdata;
   logic        s_readvalid;

   modport master (output m_addr, m_read, m_write, m_writedata,
                   input  s_readdata, s_readvalid);
   modport slave  (input  m_addr, m_read, m_write, m_writedata,
                   output s_readdata, s_readvalid);
endinterface

// File: rtl/histogram_engine.sv
// ---------------------------------------------------------------------------
// histogram_engine
// Streaming histogram: each accepted sample is classified against NUM_BINS-1
// programmable thresholds and the matching bin counter in an internal count
// RAM is incremented through a read-modify-write pipeline with forwarding.
// A clear sequencer (IDLE -> DRAIN -> CLEAR) zeroes the RAM on request.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   value_valid : sample qualifier
//   value       : unsigned sample, DATA_W bits
//   bus         : JTAG word bus (slave modport), registers and count readout
//   busy        : clear sequence in progress
// Optional feature: define HIST_DROP_CNT_EN to add a 32-bit saturating
// counter of rejected samples at word 0x202 (reads 0 when undefined).
// ---------------------------------------------------------------------------
module histogram_engine #(
   parameter int NUM_BINS = 8,
   parameter int DATA_W   = 32,
   parameter int COUNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              value_valid,
   input  logic [DATA_W-1:0] value,
   histogram_engine_if.slave bus,
   output logic              busy
);
   localparam int BIN_W = $clog2(NUM_BINS);
   localparam int CW    = BIN_W + 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRAIN = 2'd1, ST_CLEAR = 2'd2} state_t;

   // saturating increment used by the write-back stage
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (c == {COUNT_W{1'b1}}) ? c : c + COUNT_W'(1);
   endfunction

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_fsm_cnt;
   logic                r_busy;
   logic                r_enable;
   logic [DATA_W-1:0]   r_thr [NUM_BINS-1];
   logic [COUNT_W-1:0]  r_ram [NUM_BINS];
   logic                r_s0_vld, r_s1_vld;
   logic [BIN_W-1:0]    r_s0_bin, r_s1_bin;
   logic [COUNT_W-1:0]  r_s1_cnt;
   logic                r_rd_vld, r_readvalid;
   logic [31:0]         r_rd_data, r_readdata;

   logic                w_idle, w_clr_we, w_clr_req, w_accept;
   logic [BIN_W-1:0]    w_bin, w_idx, w_clr_idx;
   logic [COUNT_W-1:0]  w_s1_inc, w_fwd_cnt, w_cnt_view;
   logic                w_thr_sel, w_cnt_sel, w_ctrl_sel, w_stat_sel, w_drop_sel;
   logic [31:0]         w_rd_mux, w_drop;

   // address decode; bins are word-aligned so the low bits index directly
   assign w_idx      = bus.m_addr[BIN_W-1:0];
   assign w_thr_sel  = (bus.m_addr < 32'(NUM_BINS - 1));
   assign w_cnt_sel  = (bus.m_addr >= 32'h0000_0100) && (bus.m_addr < 32'(256 + NUM_BINS));
   assign w_ctrl_sel = (bus.m_addr == 32'h0000_0200);
   assign w_stat_sel = (bus.m_addr == 32'h0000_0201);
   assign w_drop_sel = (bus.m_addr == 32'h0000_0202);

   assign w_clr_req  = bus.m_write && w_ctrl_sel && bus.m_writedata[1] && w_idle;
   assign w_accept   = value_valid && r_enable && w_idle;
   assign w_clr_idx  = r_fsm_cnt[BIN_W-1:0];

   // write-back value, and the S1 read with forwarding of the in-flight write
   assign w_s1_inc   = sat_inc(r_s1_cnt);
   assign w_fwd_cnt  = (r_s1_vld && (r_s1_bin == r_s0_bin)) ? w_s1_inc : r_ram[r_s0_bin];
   assign w_cnt_view = (r_s1_vld && (r_s1_bin == w_idx)) ? w_s1_inc : r_ram[w_idx];

   assign busy            = r_busy;
   assign bus.s_readdata  = r_readdata;
   assign bus.s_readvalid = r_readvalid;

`ifdef HIST_DROP_CNT_EN
   logic [31:0] r_drop;

   // rejected-sample counter, restarted by a clear request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drop <= 32'd0;
      end else if (w_clr_req) begin
         r_drop <= 32'd0;
      end else if (value_valid && !w_accept && (r_drop != 32'hFFFF_FFFF)) begin
         r_drop <= r_drop + 32'd1;
      end
   end
   assign w_drop = r_drop;
`else
   assign w_drop = 32'd0;
`endif

   // bin = number of thresholds the sample meets or exceeds (order-agnostic)
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < NUM_BINS - 1; i++) begin
         if (value >= r_thr[i]) w_bin = w_bin + BIN_W'(1);
         else                   w_bin = w_bin;
      end
   end

   // clear FSM: state register, phase counter and registered busy flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_fsm_cnt <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_fsm_cnt <= (w_state_nxt != r_state) ? CW'(0) : r_fsm_cnt + CW'(1);
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   // clear FSM: next state (DRAIN lasts 2 cycles, CLEAR one cycle per bin)
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_clr_req) w_state_nxt = ST_DRAIN; else w_state_nxt = ST_IDLE;
         ST_DRAIN: if (r_fsm_cnt == CW'(1)) w_state_nxt = ST_CLEAR; else w_state_nxt = ST_DRAIN;
         ST_CLEAR: if (r_fsm_cnt == CW'(NUM_BINS - 1)) w_state_nxt = ST_IDLE; else w_state_nxt = ST_CLEAR;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // clear FSM: state decode
   always_comb begin
      w_idle   = 1'b0;
      w_clr_we = 1'b0;
      case (r_state)
         ST_IDLE:  w_idle   = 1'b1;
         ST_CLEAR: w_clr_we = 1'b1;
         default: begin
            w_idle   = 1'b0;
            w_clr_we = 1'b0;
         end
      endcase
   end

   // threshold and enable registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_enable <= 1'b0;
         for (int i = 0; i < NUM_BINS - 1; i++) r_thr[i] <= DATA_W'(i + 1) << (DATA_W - BIN_W);
      end else if (bus.m_write) begin
         if (w_thr_sel) r_thr[w_idx] <= DATA_W'(bus.m_writedata);
         if (w_ctrl_sel) r_enable <= bus.m_writedata[0];
      end
   end

   // S0 classification and S1 count read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s0_vld <= 1'b0;
         r_s0_bin <= '0;
         r_s1_vld <= 1'b0;
         r_s1_bin <= '0;
         r_s1_cnt <= '0;
      end else begin
         r_s0_vld <= w_accept;
         r_s0_bin <= w_bin;
         r_s1_vld <= r_s0_vld;
         r_s1_bin <= r_s0_bin;
         r_s1_cnt <= w_fwd_cnt;
      end
   end

   // count RAM: clear sequencer wins; the pipeline is empty while clearing
   always_ff @(posedge clk) begin
      if (w_clr_we)      r_ram[w_clr_idx] <= '0;
      else if (r_s1_vld) r_ram[r_s1_bin]  <= w_s1_inc;
   end

   // read data mux; counts read as 0 while the clear sequence runs
   always_comb begin
      w_rd_mux = 32'd0;
      if (w_thr_sel) begin
         w_rd_mux = 32'(r_thr[w_idx]);
      end else if (w_cnt_sel) begin
         if (r_busy) w_rd_mux = 32'd0;
         else        w_rd_mux = 32'(w_cnt_view);
      end else if (w_ctrl_sel) begin
         w_rd_mux = {31'd0, r_enable};
      end else if (w_stat_sel) begin
         w_rd_mux = {31'd0, r_busy};
      end else if (w_drop_sel) begin
         w_rd_mux = w_drop;
      end else begin
         w_rd_mux = 32'd0;
      end
   end

   // two-stage read return; data captured before a same-cycle write lands
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_vld    <= 1'b0;
         r_rd_data   <= 32'd0;
         r_readvalid <= 1'b0;
         r_readdata  <= 32'd0;
      end else begin
         r_rd_vld    <= bus.m_read;
         r_readvalid <= r_rd_vld;
         if (bus.m_read) r_rd_data  <= w_rd_mux;
         if (r_rd_vld)   r_readdata <= r_rd_data;
      end
   end
endmodule

// File: tb/tb_histogram_engine.sv
module tb_histogram_engine;
   logic        clk = 1'b0;
   logic        rst;
   logic        value_valid;
   logic [31:0] value;
   logic        busy1, busy2;

   histogram_engine_if bus1 ();
   histogram_engine_if bus2 ();

   // second instance with 4-bit counters sees identical traffic
   assign bus2.m_addr      = bus1.m_addr;
   assign bus2.m_read      = bus1.m_read;
   assign bus2.m_write     = bus1.m_write;
   assign bus2.m_writedata = bus1.m_writedata;

   histogram_engine dut (
      .clk(clk), .rst(rst), .value_valid(value_valid), .value(value),
      .bus(bus1.slave), .busy(busy1));

   histogram_engine #(.COUNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .value_valid(value_valid), .value(value),
      .bus(bus2.slave), .busy(busy2));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model
   logic [31:0] m_thr [7];
   logic [31:0] m_cnt [8];
   logic        m_en;
   int          m_busy_left;
   int          m_drop;
   bit          stream_on;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int bin_of(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 7; i++) if (v >= m_thr[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] rand_val();
      int k = $urandom_range(0, 6);
      case ($urandom_range(0, 2))
         0:       return $urandom;
         1:       return m_thr[k];
         default: return m_thr[k] - 32'd1;
      endcase
   endfunction

   function automatic logic [31:0] drop_exp();
`ifdef HIST_DROP_CNT_EN
      return 32'(m_drop);
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 7; i++) m_thr[i] = 32'(i + 1) << 29;
      m_en = 1'b0;
      m_busy_left = 0;
      m_drop = 0;
   endtask

   // one clock: update the model with what is being driven, then check busy
   task automatic cycle();
      bit busy_now;
      if (stream_on) begin
         value_valid = ($urandom_range(0, 3) != 0);
         value = rand_val();
      end
      busy_now = (m_busy_left != 0);
      if (value_valid && m_en && !busy_now) begin
         int b = bin_of(value);
         if (m_cnt[b] != 32'hFFFF_FFFF) m_cnt[b] = m_cnt[b] + 32'd1;
      end else if (value_valid) begin
         m_drop++;
      end
      if (m_busy_left > 0) m_busy_left--;
      if (bus1.m_write) begin
         if (bus1.m_addr < 32'd7) begin
            m_thr[bus1.m_addr] = bus1.m_writedata;
         end else if (bus1.m_addr == 32'h200) begin
            m_en = bus1.m_writedata[0];
            if (bus1.m_writedata[1] && !busy_now) begin
               m_busy_left = 10;
               m_drop = 0;
               for (int i = 0; i < 8; i++) m_cnt[i] = 32'd0;
            end
         end
      end
      @(posedge clk);
      #1;
      check("busy", {31'd0, busy1}, {31'd0, m_busy_left != 0});
      check("busy_sat", {31'd0, busy2}, {31'd0, m_busy_left != 0});
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus1.m_addr = a;
      bus1.m_writedata = d;
      bus1.m_write = 1'b1;
      cycle();
      bus1.m_write = 1'b0;
   endtask

   // read with latency check; caller may pre-arm m_write for a collision
   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] exp2 = exp;
      if (a >= 32'h100 && a < 32'h108 && exp > 32'd15) exp2 = 32'd15;
      bus1.m_addr = a;
      bus1.m_read = 1'b1;
      cycle();
      bus1.m_read = 1'b0;
      bus1.m_write = 1'b0;
      check({tag, "_rv_early"}, {31'd0, bus1.s_readvalid}, 32'd0);
      cycle();
      check({tag, "_rv"}, {31'd0, bus1.s_readvalid}, 32'd1);
      check(tag, bus1.s_readdata, exp);
      check({tag, "_sat"}, bus2.s_readdata, exp2);
   endtask

   task automatic rd_counts(input string tag);
      for (int i = 0; i < 8; i++) rd($sformatf("%s_cnt%0d", tag, i), 32'h100 + 32'(i), m_cnt[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      logic [31:0] old;
      rst = 1'b0;
      value_valid = 1'b0;
      value = 32'd0;
      bus1.m_addr = 32'd0;
      bus1.m_read = 1'b0;
      bus1.m_write = 1'b0;
      bus1.m_writedata = 32'd0;
      stream_on = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) m_cnt[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy1}, 32'd0);
      check("rst_rv", {31'd0, bus1.s_readvalid}, 32'd0);
      check("rst_rdata", bus1.s_readdata, 32'd0);
      rst = 1'b1;

      // reset defaults and unmapped addresses
      for (int i = 0; i < 7; i++) rd($sformatf("thr%0d", i), 32'(i), 32'(i + 1) * 32'h2000_0000);
      rd("unmapped_007", 32'h007, 32'd0);
      rd("ctrl_rst", 32'h200, 32'd0);
      rd("status_rst", 32'h201, 32'd0);
      rd("unmapped_300", 32'h300, 32'd0);

      // clear sequence: busy for exactly 10 cycles
      wr(32'h200, 32'h2);
      nb = busy1 ? 1 : 0;
      repeat (12) begin
         cycle();
         if (busy1) nb++;
      end
      check("busy_len", 32'(nb), 32'd10);
      wr(32'h200, 32'h1);
      value_valid = 1'b1;
      value = 32'h10;        cycle();
      value = 32'h3000_0000; cycle();
      value = 32'hFFFF_FFFF; cycle();
      value_valid = 1'b0;
      idle(4);
      check("model_sanity_bin7", m_cnt[7], 32'd1);
      rd_counts("clr");
      rd("ctrl_en", 32'h200, 32'd1);

      // forwarding: back-to-back samples to one bin
      value_valid = 1'b1;
      value = 32'h5000_0000;
      repeat (100) cycle();
      value_valid = 1'b0;
      idle(4);
      rd("fwd_cnt2", 32'h102, m_cnt[2]);

      // saturation on the 4-bit instance: 20 samples into bin 0
      wr(32'h200, 32'h3);
      idle(10);
      value_valid = 1'b1;
      value = 32'd0;
      repeat (20) cycle();
      value_valid = 1'b0;
      idle(4);
      rd("sat_cnt0", 32'h100, m_cnt[0]);

      // read/write collision on T[0]
      old = m_thr[0];
      bus1.m_writedata = 32'h1234_5678;
      bus1.m_write = 1'b1;
      rd("collide_old", 32'h000, old);
      rd("collide_new", 32'h000, 32'h1234_5678);

      // random traffic with threshold rewrites and an enable gap
      stream_on = 1'b1;
      for (int r = 0; r < 6; r++) begin
         idle(20);
         wr(32'($urandom_range(0, 6)), $urandom);
      end
      wr(32'h200, 32'h0);
      idle(15);
      wr(32'h200, 32'h1);
      idle(20);
      stream_on = 1'b0;
      value_valid = 1'b0;
      idle(4);
      rd_counts("rnd");
      for (int i = 0; i < 7; i++) rd($sformatf("rnd_thr%0d", i), 32'(i), m_thr[i]);
      rd("rnd_drop", 32'h202, drop_exp());

      // clear in the middle of a continuous stream
      stream_on = 1'b1;
      idle(15);
      wr(32'h200, 32'h3);
      rd("busy_cnt_read", 32'h100, 32'd0);
      rd("status_busy", 32'h201, 32'd1);
      while (m_busy_left > 1) cycle();
      stream_on = 1'b0;
      value_valid = 1'b0;
      cycle();
      check("busy_fell", {31'd0, busy1}, 32'd0);
      rd_counts("post_clr");
      rd("drop_busy", 32'h202, drop_exp());
      stream_on = 1'b1;
      idle(30);
      stream_on = 1'b0;
      value_valid = 1'b0;
      idle(4);
      rd_counts("resume");

      // reset in the middle of a clear with traffic
      stream_on = 1'b1;
      idle(5);
      wr(32'h200, 32'h3);
      cycle();
      stream_on = 1'b0;
      value_valid = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      check("mid_rst_busy", {31'd0, busy1}, 32'd0);
      check("mid_rst_rv", {31'd0, bus1.s_readvalid}, 32'd0);
      check("mid_rst_rdata", bus1.s_readdata, 32'd0);
      rst = 1'b1;
      rd("mid_rst_thr0", 32'h000, 32'h2000_0000);
      rd("mid_rst_ctrl", 32'h200, 32'd0);
      rd("mid_rst_drop", 32'h202, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
